led_blink_seq: RTL and testbench

- Consumes the single-cycle ~102 Hz tick enable produced by the board clock-divider stage.
- Drives one LED in one of four modes: off, on, continuous blink, or N-pulse burst. The blink period is programmable in ticks.
- All logic runs in the system clock domain. The tick is a clock enable, never a clock.
- Provides busy/done status for a higher-level panel controller.

---
 rtl/led_blink_seq_pkg.sv | 19 +
 rtl/led_blink_seq_tick_phase_cnt.sv | 34 +++
 rtl/led_blink_seq.sv | 125 ++++++++++++
 tb/tb_led_blink_seq.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_blink_seq_pkg.sv
// Shared encodings and the default blink half period for the LED blink sequencer.
package led_blink_seq_pkg;

  localparam int DEFAULT_HALF = 101;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_BURST = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HIGH = 2'b01,
    ST_LOW  = 2'b10
  } state_e;

endpackage

// File: rtl/led_blink_seq_tick_phase_cnt.sv
// Tick-qualified phase counter: counts tick_in pulses and flags the last tick of a phase.
module tick_phase_cnt #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             tick_in,
  input  logic [CNT_W-1:0] limit,
  output logic             term
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign term = tick_in && (cnt_q == (limit - CNT_W'(1)));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick_in) begin
      cnt_d = term ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_blink_seq.sv
// LED driver: off / on / continuous blink / N-pulse burst, paced by a slow tick enable.
module led_blink_seq #(
  parameter int CNT_W        = 9,
  parameter int BURST_W      = 4,
  parameter int DEFAULT_HALF = led_blink_seq_pkg::DEFAULT_HALF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_in,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [CNT_W-1:0]   half_period,
  input  logic [BURST_W-1:0] burst_count,
  output logic               light_out,
  output logic               busy,
  output logic               done
);

  import led_blink_seq_pkg::*;

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [CNT_W-1:0]   hp_q, hp_d;
  logic [BURST_W-1:0] burst_left_q, burst_left_d;
  logic               light_q, light_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               term;
  logic               cnt_clear;

  // Counter is held at zero while idle, so a tick coincident with start is not counted.
  assign cnt_clear = stop || (state_q == ST_IDLE);

  tick_phase_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .tick_in (tick_in),
    .limit   (hp_q),
    .term    (term)
  );

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    hp_d         = hp_q;
    burst_left_d = burst_left_q;
    light_d      = light_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      light_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          light_d = (mode == MODE_ON);
          busy_d  = 1'b0;
          if (start && (mode == MODE_BLINK || mode == MODE_BURST)) begin
            hp_d         = (half_period == '0) ? CNT_W'(DEFAULT_HALF) : half_period;
            mode_d       = mode_e'(mode);
            burst_left_d = (burst_count == '0) ? BURST_W'(1) : burst_count;
            light_d      = 1'b1;
            busy_d       = 1'b1;
            state_d      = ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (term) begin
            light_d = 1'b0;
            state_d = ST_LOW;
          end
        end
        ST_LOW: begin
          if (term) begin
            if (mode_q == MODE_BURST && burst_left_q == BURST_W'(1)) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              light_d = 1'b0;
            end else begin
              if (mode_q == MODE_BURST) begin
                burst_left_d = burst_left_q - BURST_W'(1);
              end
              light_d = 1'b1;
              state_d = ST_HIGH;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          light_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_OFF;
      hp_q         <= '0;
      burst_left_q <= '0;
      light_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      hp_q         <= hp_d;
      burst_left_q <= burst_left_d;
      light_q      <= light_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign light_out = light_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_led_blink_seq.sv
// Self-checking bench for led_blink_seq: vector table, directed corner sequences, random vs. model.
module tb_led_blink_seq;

  import led_blink_seq_pkg::*;

  logic       clk;
  logic       reset;
  logic       tick_in;
  logic       start;
  logic       stop;
  logic [1:0] mode;
  logic [8:0] half_period;
  logic [3:0] burst_count;
  logic       light_out;
  logic       busy;
  logic       done;

  int checks;
  int errors;

  typedef struct {
    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic [8:0] half;
    logic [3:0] burst;
    logic       tick;
    logic       e_light;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t vecs[$];

  // reference model state: elapsed ticks since the start of a sequence
  bit m_active;
  int m_mode;
  int m_hp;
  int m_n;
  int m_ticks;
  bit m_light;
  bit m_busy;
  bit m_done;

  led_blink_seq dut (
    .clk         (clk),
    .reset       (reset),
    .tick_in     (tick_in),
    .start       (start),
    .stop        (stop),
    .mode        (mode),
    .half_period (half_period),
    .burst_count (burst_count),
    .light_out   (light_out),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic t);
    @(negedge clk);
    tick_in = t;
    @(posedge clk);
    #1;
    start   = 1'b0;
    stop    = 1'b0;
    tick_in = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic el, input logic eb, input logic ed);
    checks++;
    if (light_out !== el || busy !== eb || done !== ed) begin
      errors++;
      $display("[TB] FAIL %s: light/busy/done = %b%b%b, expected %b%b%b",
               name, light_out, busy, done, el, eb, ed);
    end
  endtask

  task automatic runTicks(input int k);
    repeat (k) begin
      applyStimulus(1'b1);
      repeat (3) applyStimulus(1'b0);
    end
  endtask

  // Whole-sequence view: light is on during even-numbered phases of hp ticks each.
  task automatic modelStep(input bit s_start, input bit s_stop, input int s_mode,
                           input int s_half, input int s_burst, input bit s_tick);
    m_done = 1'b0;
    if (s_stop) begin
      m_active = 1'b0;
      m_light  = 1'b0;
      m_busy   = 1'b0;
    end else if (!m_active) begin
      if (s_start && s_mode >= 2) begin
        m_active = 1'b1;
        m_mode   = s_mode;
        m_hp     = (s_half == 0) ? DEFAULT_HALF : s_half;
        m_n      = (s_burst == 0) ? 1 : s_burst;
        m_ticks  = 0;
        m_light  = 1'b1;
        m_busy   = 1'b1;
      end else begin
        m_light = (s_mode == 1);
        m_busy  = 1'b0;
      end
    end else if (s_tick) begin
      m_ticks++;
      if (m_mode == 3 && m_ticks == 2 * m_hp * m_n) begin
        m_active = 1'b0;
        m_done   = 1'b1;
        m_light  = 1'b0;
        m_busy   = 1'b0;
      end else begin
        m_light = ((m_ticks / m_hp) % 2) == 0;
      end
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    tick_in     = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    mode        = 2'b00;
    half_period = 9'd0;
    burst_count = 4'd0;
    #12;
    checkOutput("reset_values", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // ---------------- table-driven vectors ----------------
    vecs.push_back('{1'b0, 1'b0, 2'b01, 9'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 9'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 2'b01, 9'd3, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 2'b10, 9'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 2'b10, 9'd1, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 9'd1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 9'd1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 9'd1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 9'd1, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 9'd1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 2'b00, 9'd1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 2'b11, 9'd1, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'b11, 9'd1, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'b11, 9'd1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'b11, 9'd1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 2'b11, 9'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < vecs.size(); i++) begin
      start       = vecs[i].start;
      stop        = vecs[i].stop;
      mode        = vecs[i].mode;
      half_period = vecs[i].half;
      burst_count = vecs[i].burst;
      applyStimulus(vecs[i].tick);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_light, vecs[i].e_busy, vecs[i].e_done);
    end

    // ---------------- BLINK hp=3, mid-sequence changes ignored ----------------
    mode = 2'b10; half_period = 9'd3; start = 1'b1;
    applyStimulus(1'b0);
    checkOutput("blink_rise", 1'b1, 1'b1, 1'b0);
    runTicks(2);
    checkOutput("blink_high2", 1'b1, 1'b1, 1'b0);
    runTicks(1);
    checkOutput("blink_fall3", 1'b0, 1'b1, 1'b0);
    half_period = 9'd7;
    mode = 2'b01;
    runTicks(2);
    checkOutput("blink_low2", 1'b0, 1'b1, 1'b0);
    runTicks(1);
    checkOutput("blink_rise3", 1'b1, 1'b1, 1'b0);
    runTicks(1);
    start = 1'b1; mode = 2'b10;
    applyStimulus(1'b0);
    runTicks(2);
    checkOutput("start_busy_ignored", 1'b0, 1'b1, 1'b0);
    stop = 1'b1;
    applyStimulus(1'b0);
    checkOutput("blink_stop", 1'b0, 1'b0, 1'b0);

    // ---------------- BURST hp=2 n=2 ----------------
    mode = 2'b11; half_period = 9'd2; burst_count = 4'd2; start = 1'b1;
    applyStimulus(1'b0);
    checkOutput("burst_rise", 1'b1, 1'b1, 1'b0);
    runTicks(2);
    checkOutput("burst_low1", 1'b0, 1'b1, 1'b0);
    runTicks(2);
    checkOutput("burst_high2", 1'b1, 1'b1, 1'b0);
    runTicks(2);
    checkOutput("burst_low2", 1'b0, 1'b1, 1'b0);
    runTicks(1);
    applyStimulus(1'b1);
    checkOutput("burst_done", 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0);
    checkOutput("burst_done_1clk", 1'b0, 1'b0, 1'b0);

    // ---------------- defaults: hp=0 -> 101, n=0 -> 1 ----------------
    mode = 2'b11; half_period = 9'd0; burst_count = 4'd0; start = 1'b1;
    applyStimulus(1'b0);
    runTicks(100);
    checkOutput("default_high100", 1'b1, 1'b1, 1'b0);
    runTicks(1);
    checkOutput("default_fall101", 1'b0, 1'b1, 1'b0);
    runTicks(100);
    checkOutput("default_low100", 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1);
    checkOutput("default_done", 1'b0, 1'b0, 1'b1);

    // ---------------- asynchronous reset mid-sequence ----------------
    mode = 2'b11; half_period = 9'd2; burst_count = 4'd3; start = 1'b1;
    applyStimulus(1'b0);
    runTicks(1);
    checkOutput("pre_reset", 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("async_reset", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0);
    checkOutput("after_reset", 1'b0, 1'b0, 1'b0);

    // ---------------- randomized run against the reference model ----------------
    stop = 1'b1; mode = 2'b00;
    applyStimulus(1'b0);
    m_active = 1'b0; m_light = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit s_start, s_stop, s_tick;
      s_start     = ($urandom_range(0, 19) == 0);
      s_stop      = ($urandom_range(0, 199) == 0);
      s_tick      = (i % 4 == 0);
      start       = s_start;
      stop        = s_stop;
      mode        = 2'($urandom_range(0, 3));
      half_period = 9'($urandom_range(1, 5));
      burst_count = 4'($urandom_range(0, 3));
      modelStep(s_start, s_stop, int'(mode), int'(half_period), int'(burst_count), s_tick);
      applyStimulus(s_tick);
      checkOutput($sformatf("random%0d", i), m_light, m_busy, m_done);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
